phrase_sequencer: RTL and testbench

Line sequencer that drives the four-channel phrase playback datapath from memory. It walks a chain table of phrase IDs, fetches each line's four channel entries from a shared synchronous phrase RAM into a shadow buffer, and commits them atomically on every tempo tick. It sits between the phrase/chain RAMs and the playback datapath's `current_entry` inputs, and owns the tempo accumulator.

---
 rtl/phrase_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_phrase_sequencer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phrase_sequencer.sv
// Phrase line sequencer: walks the chain table, fetches four channel entries
// per line from the phrase RAM into a shadow buffer, and commits them to the
// playback datapath on tempo ticks generated by an internal accumulator.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | stopped, outputs silent, waiting for play_enable
// S_CHAIN_RD | reading the chain table for the next step's phrase ID
// S_ENTRY_RD | issuing/capturing the four channel reads into the shadow
// S_READY    | shadow valid, waiting for a tick (or end-of-song tick)
// S_DONE     | song finished, silent, waiting for play_enable to drop
module phrase_sequencer #(
    parameter int unsigned          ACC_WIDTH   = 48,
    parameter logic [ACC_WIDTH-1:0] TEMPO_SCALE = ACC_WIDTH'(46912),
    parameter logic [15:0]          SILENCE     = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst_active_low,
    input  logic        play_enable,
    input  logic        loop_enable,
    input  logic [8:0]  tempo,
    input  logic [3:0]  chain_last,
    output logic [3:0]  chain_addr,
    input  logic [5:0]  chain_rdata,
    output logic [11:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [15:0] mem_rdata,
    output logic [15:0] current_entry [0:3],
    output logic [3:0]  line_count,
    output logic [3:0]  chain_step,
    output logic        line_strobe,
    output logic        playing
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHAIN_RD,
        S_ENTRY_RD,
        S_READY,
        S_DONE
    } state_t;

    state_t               state;
    logic                 chain_ph;
    logic [2:0]           rd_cnt;
    logic [5:0]           phrase_id;
    logic [3:0]           next_step;
    logic [3:0]           next_line;
    logic [15:0]          shadow [0:3];
    logic                 first_line;
    logic                 end_of_song;
    logic                 tick_pending;
    logic [ACC_WIDTH-1:0] acc;

    logic [ACC_WIDTH-1:0] inc;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 tick;
    logic                 commit_due;
    logic                 rd_issue;
    logic [5:0]           rd_id;
    logic [1:0]           rd_ch;

    // Tempo increment and carry-out tick; accumulator only runs while playing.
    always_comb begin
        inc        = ACC_WIDTH'(tempo) * TEMPO_SCALE;
        acc_sum    = {1'b0, acc} + {1'b0, inc};
        tick       = acc_sum[ACC_WIDTH] & playing;
        commit_due = first_line | tick | tick_pending;
    end

    // Read port is combinational so the channel-0 read can use chain_rdata in
    // the same cycle it arrives; this is what makes the 7-cycle start work.
    always_comb begin
        rd_issue  = ((state == S_CHAIN_RD) && chain_ph) ||
                    ((state == S_ENTRY_RD) && (rd_cnt < 3'd4));
        rd_id     = (state == S_CHAIN_RD) ? chain_rdata : phrase_id;
        rd_ch     = (state == S_CHAIN_RD) ? 2'd0 : rd_cnt[1:0];
        mem_rd_en = rd_issue;
        mem_addr  = rd_issue ? {rd_id, next_line, rd_ch} : 12'd0;
    end

    // Sequencer FSM, tempo accumulator and committed outputs.
    always_ff @(posedge clk) begin
        if (!rst_active_low || !play_enable) begin
            state        <= S_IDLE;
            chain_ph     <= 1'b0;
            rd_cnt       <= 3'd0;
            phrase_id    <= 6'd0;
            next_step    <= 4'd0;
            next_line    <= 4'd0;
            first_line   <= 1'b0;
            end_of_song  <= 1'b0;
            tick_pending <= 1'b0;
            acc          <= '0;
            chain_addr   <= 4'd0;
            line_count   <= 4'd0;
            chain_step   <= 4'd0;
            line_strobe  <= 1'b0;
            playing      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                current_entry[i] <= SILENCE;
                shadow[i]        <= SILENCE;
            end
        end else begin
            line_strobe <= 1'b0;
            if (playing) begin
                acc <= acc_sum[ACC_WIDTH-1:0];
            end
            // A tick outside READY is held for one commit; extras collapse.
            if (tick) begin
                tick_pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    state        <= S_CHAIN_RD;
                    chain_ph     <= 1'b0;
                    next_step    <= 4'd0;
                    next_line    <= 4'd0;
                    chain_addr   <= 4'd0;
                    first_line   <= 1'b1;
                    end_of_song  <= 1'b0;
                    tick_pending <= 1'b0;
                end

                S_CHAIN_RD: begin
                    if (!chain_ph) begin
                        chain_ph <= 1'b1;
                    end else begin
                        phrase_id <= chain_rdata;
                        rd_cnt    <= 3'd1;
                        state     <= S_ENTRY_RD;
                    end
                end

                S_ENTRY_RD: begin
                    if (rd_cnt != 3'd0) begin
                        shadow[2'(rd_cnt - 3'd1)] <= mem_rdata;
                    end
                    if (rd_cnt == 3'd4) begin
                        state <= S_READY;
                    end else begin
                        rd_cnt <= rd_cnt + 3'd1;
                    end
                end

                S_READY: begin
                    if (commit_due) begin
                        tick_pending <= 1'b0;
                        if (end_of_song) begin
                            for (int i = 0; i < 4; i++) begin
                                current_entry[i] <= SILENCE;
                            end
                            playing <= 1'b0;
                            state   <= S_DONE;
                        end else begin
                            for (int i = 0; i < 4; i++) begin
                                current_entry[i] <= shadow[i];
                            end
                            line_count  <= next_line;
                            chain_step  <= next_step;
                            line_strobe <= 1'b1;
                            playing     <= 1'b1;
                            first_line  <= 1'b0;
                            // First line restarts the beat so it lasts a full period.
                            if (first_line) begin
                                acc <= '0;
                            end
                            if (next_line != 4'd15) begin
                                next_line <= next_line + 4'd1;
                                rd_cnt    <= 3'd0;
                                state     <= S_ENTRY_RD;
                            end else if (next_step < chain_last) begin
                                next_step  <= next_step + 4'd1;
                                next_line  <= 4'd0;
                                chain_addr <= next_step + 4'd1;
                                chain_ph   <= 1'b0;
                                state      <= S_CHAIN_RD;
                            end else if (loop_enable) begin
                                next_step  <= 4'd0;
                                next_line  <= 4'd0;
                                chain_addr <= 4'd0;
                                chain_ph   <= 1'b0;
                                state      <= S_CHAIN_RD;
                            end else begin
                                end_of_song <= 1'b1;
                            end
                        end
                    end
                end

                S_DONE: begin
                    state <= S_DONE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phrase_sequencer.sv
// Bench for phrase_sequencer: behavioural chain/phrase RAMs, a scoreboard of
// expected commits checked on every line_strobe, and per-scenario tasks.
module tb_phrase_sequencer;

    logic        clk = 1'b0;
    logic        rst_active_low;
    logic        play_enable;
    logic        loop_enable;
    logic [8:0]  tempo;
    logic [3:0]  chain_last;
    logic [3:0]  chain_addr;
    logic [5:0]  chain_rdata;
    logic [11:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rdata;
    logic [15:0] current_entry [0:3];
    logic [3:0]  line_count;
    logic [3:0]  chain_step;
    logic        line_strobe;
    logic        playing;

    phrase_sequencer #(
        .ACC_WIDTH  (48),
        .TEMPO_SCALE(48'h0100_0000_0000),
        .SILENCE    (16'hFF00)
    ) dut (
        .clk           (clk),
        .rst_active_low(rst_active_low),
        .play_enable   (play_enable),
        .loop_enable   (loop_enable),
        .tempo         (tempo),
        .chain_last    (chain_last),
        .chain_addr    (chain_addr),
        .chain_rdata   (chain_rdata),
        .mem_addr      (mem_addr),
        .mem_rd_en     (mem_rd_en),
        .mem_rdata     (mem_rdata),
        .current_entry (current_entry),
        .line_count    (line_count),
        .chain_step    (chain_step),
        .line_strobe   (line_strobe),
        .playing       (playing)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:4095];
    logic [5:0]  chain_tab [0:15];

    always @(posedge clk) begin
        chain_rdata <= chain_tab[chain_addr];
        if (mem_rd_en === 1'b1) mem_rdata <= ram[mem_addr];
    end

    typedef struct packed {
        logic [3:0]  step;
        logic [3:0]  line;
        logic [63:0] ent;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   strobe_cnt = 0;
    int   last_strobe_cyc = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Commit monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en && line_strobe === 1'b1) begin
            exp_t        e;
            logic [63:0] got;
            got = {current_entry[0], current_entry[1], current_entry[2], current_entry[3]};
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got step=%0d line=%0d entries=%h, required no strobe",
                         chain_step, line_count, got);
            end else begin
                e = sb_q.pop_front();
                if (got !== e.ent || line_count !== e.line || chain_step !== e.step || playing !== 1'b1) begin
                    errors++;
                    $display("FAIL commit: got step=%0d line=%0d entries=%h playing=%b, required step=%0d line=%0d entries=%h playing=1",
                             chain_step, line_count, got, playing, e.step, e.line, e.ent);
                end
            end
            strobe_cnt++;
            last_strobe_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_line(input logic [3:0] s, input logic [3:0] l);
        exp_t       e;
        logic [5:0] id;
        id     = chain_tab[s];
        e.step = s;
        e.line = l;
        e.ent  = {ram[{id, l, 2'd0}], ram[{id, l, 2'd1}], ram[{id, l, 2'd2}], ram[{id, l, 2'd3}]};
        sb_q.push_back(e);
    endtask

    task automatic push_run(input int n, input logic [3:0] last, input bit loop);
        logic [3:0] s;
        logic [3:0] l;
        s = 4'd0;
        l = 4'd0;
        for (int i = 0; i < n; i++) begin
            push_line(s, l);
            if (l != 4'd15) l = l + 4'd1;
            else if (s < last) begin s = s + 4'd1; l = 4'd0; end
            else if (loop) begin s = 4'd0; l = 4'd0; end
            else break;
        end
    endtask

    task automatic wait_strobes(input int n, input int budget, output bit ok);
        int target;
        int k;
        target = strobe_cnt + n;
        k = 0;
        while (strobe_cnt < target && k < budget) begin
            step();
            k++;
        end
        ok = (strobe_cnt >= target);
    endtask

    task automatic stop_play();
        play_enable = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        logic [63:0] got;
        repeat (3) step();
        got = {current_entry[0], current_entry[1], current_entry[2], current_entry[3]};
        checks++;
        if (got !== {4{16'hFF00}}) begin
            errors++; $display("FAIL reset_entries: got %h, required %h", got, {4{16'hFF00}});
        end
        checks++;
        if (line_count !== 4'd0 || chain_step !== 4'd0 || chain_addr !== 4'd0 || mem_addr !== 12'd0) begin
            errors++; $display("FAIL reset_counts: got line=%h step=%h caddr=%h maddr=%h, required all 0",
                               line_count, chain_step, chain_addr, mem_addr);
        end
        checks++;
        if (mem_rd_en !== 1'b0 || line_strobe !== 1'b0 || playing !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got rd=%b strobe=%b playing=%b, required 0 0 0",
                               mem_rd_en, line_strobe, playing);
        end
        rst_active_low = 1'b1;
        mon_en = 1'b1;
        step();
        // reset in the middle of a fetch
        tempo = 9'd120;
        play_enable = 1'b1;
        repeat (3) step();
        checks++;
        if (mem_rd_en !== 1'b1) begin
            errors++; $display("FAIL midfetch_active: got rd=%b, required 1", mem_rd_en);
        end
        rst_active_low = 1'b0;
        step();
        got = {current_entry[0], current_entry[1], current_entry[2], current_entry[3]};
        checks++;
        if (got !== {4{16'hFF00}} || mem_rd_en !== 1'b0 || playing !== 1'b0) begin
            errors++; $display("FAIL midfetch_reset: got entries=%h rd=%b playing=%b, required %h 0 0",
                               got, mem_rd_en, playing, {4{16'hFF00}});
        end
        play_enable = 1'b0;
        rst_active_low = 1'b1;
        step();
    endtask

    task automatic test_start();
        logic        rd   [0:8];
        logic [11:0] addr [0:8];
        logic        stb  [0:8];
        logic        ply  [0:8];
        logic [63:0] got;
        int          s0;
        chain_last  = 4'd0;
        loop_enable = 1'b0;
        tempo       = 9'd8;
        push_line(4'd0, 4'd0);
        s0 = strobe_cnt;
        play_enable = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            step();
            rd[k] = mem_rd_en; addr[k] = mem_addr; stb[k] = line_strobe; ply[k] = playing;
        end
        for (int k = 0; k <= 5; k++) begin
            logic        er;
            logic [11:0] ea;
            er = (k >= 1 && k <= 4);
            ea = {chain_tab[0], 4'd0, 2'(k - 1)};
            checks++;
            if (rd[k] !== er || (er && addr[k] !== ea)) begin
                errors++; $display("FAIL start_read k=%0d: got rd=%b addr=%h, required rd=%b addr=%h",
                                   k, rd[k], addr[k], er, er ? ea : 12'd0);
            end
        end
        checks++;
        if (stb[6] !== 1'b0 || stb[7] !== 1'b1 || ply[6] !== 1'b0 || ply[7] !== 1'b1) begin
            errors++; $display("FAIL start_latency: got strobe N+6/N+7=%b/%b playing=%b/%b, required 0/1 0/1",
                               stb[6], stb[7], ply[6], ply[7]);
        end
        checks++;
        if (strobe_cnt - s0 !== 1) begin
            errors++; $display("FAIL start_count: got %0d strobes, required 1", strobe_cnt - s0);
        end
        play_enable = 1'b0;
        step();
        got = {current_entry[0], current_entry[1], current_entry[2], current_entry[3]};
        checks++;
        if (got !== {4{16'hFF00}} || playing !== 1'b0 || line_count !== 4'd0) begin
            errors++; $display("FAIL stop_silence: got entries=%h playing=%b line=%0d, required %h 0 0",
                               got, playing, line_count, {4{16'hFF00}});
        end
        step();
    endtask

    task automatic test_tempo_period();
        bit ok;
        int t0;
        int t1;
        int t2;
        tempo = 9'd8;
        chain_last = 4'd0;
        loop_enable = 1'b0;
        push_run(3, 4'd0, 1'b0);
        play_enable = 1'b1;
        wait_strobes(1, 20, ok);  t0 = last_strobe_cyc;
        if (ok) begin wait_strobes(1, 64, ok); t1 = last_strobe_cyc; end
        if (ok) begin wait_strobes(1, 64, ok); t2 = last_strobe_cyc; end
        play_enable = 1'b0;
        checks++;
        if (!ok) begin
            errors++; $display("FAIL tempo_timeout: got %0d strobes, required 3", strobe_cnt);
        end else if (t1 - t0 !== 32 || t2 - t1 !== 32) begin
            errors++; $display("FAIL tempo_period: got %0d/%0d cycles, required 32/32", t1 - t0, t2 - t1);
        end
        sb_q.delete();
        stop_play();
    endtask

    task automatic test_line_advance();
        bit ok;
        int tprev;
        tempo = 9'd120;
        push_run(4, 4'd0, 1'b0);
        play_enable = 1'b1;
        wait_strobes(1, 20, ok);
        tprev = last_strobe_cyc;
        for (int i = 1; i < 4; i++) begin
            wait_strobes(1, 20, ok);
            checks++;
            if (!ok || last_strobe_cyc - tprev !== 6) begin
                errors++; $display("FAIL line_period %0d: got %0d cycles (ok=%b), required 6",
                                   i, last_strobe_cyc - tprev, ok);
            end
            tprev = last_strobe_cyc;
        end
        play_enable = 1'b0;
        sb_q.delete();
        stop_play();
    endtask

    task automatic test_chain_loop();
        bit ok;
        int tprev;
        tempo = 9'd120;
        chain_last = 4'd1;
        loop_enable = 1'b1;
        push_run(34, 4'd1, 1'b1);
        play_enable = 1'b1;
        wait_strobes(1, 20, ok);
        tprev = last_strobe_cyc;
        for (int i = 2; i <= 34 && ok; i++) begin
            wait_strobes(1, 20, ok);
            if (i == 17 || i == 33) begin
                checks++;
                if (last_strobe_cyc - tprev !== 7) begin
                    errors++; $display("FAIL chain_period strobe %0d: got %0d cycles, required 7",
                                       i, last_strobe_cyc - tprev);
                end
            end
            if (i == 16 || i == 32) begin
                checks++;
                if (chain_addr !== ((i == 16) ? 4'd1 : 4'd0)) begin
                    errors++; $display("FAIL chain_addr after strobe %0d: got %0d, required %0d",
                                       i, chain_addr, (i == 16) ? 1 : 0);
                end
            end
            tprev = last_strobe_cyc;
        end
        play_enable = 1'b0;
        checks++;
        if (!ok) begin
            errors++; $display("FAIL chain_timeout: got %0d queued lines left, required 0", sb_q.size());
        end
        sb_q.delete();
        stop_play();
    endtask

    task automatic test_end_of_song();
        bit          ok;
        int          k;
        int          s0;
        bit          saw_rd;
        logic [63:0] got;
        tempo = 9'd120;
        chain_last = 4'd1;
        loop_enable = 1'b0;
        push_run(32, 4'd1, 1'b0);
        play_enable = 1'b1;
        wait_strobes(32, 300, ok);
        s0 = strobe_cnt;
        k = 0;
        while (playing === 1'b1 && k < 20) begin step(); k++; end
        got = {current_entry[0], current_entry[1], current_entry[2], current_entry[3]};
        checks++;
        if (!ok || playing !== 1'b0 || got !== {4{16'hFF00}}) begin
            errors++; $display("FAIL eos_silence: got ok=%b playing=%b entries=%h, required 1 0 %h",
                               ok, playing, got, {4{16'hFF00}});
        end
        saw_rd = 1'b0;
        tempo = 9'd0;
        for (int i = 0; i < 30; i++) begin step(); if (mem_rd_en === 1'b1) saw_rd = 1'b1; end
        tempo = 9'd120;
        for (int i = 0; i < 30; i++) begin step(); if (mem_rd_en === 1'b1) saw_rd = 1'b1; end
        checks++;
        if (strobe_cnt !== s0 || playing !== 1'b0 || saw_rd) begin
            errors++; $display("FAIL eos_done_hold: got %0d extra strobes playing=%b reads=%b, required 0 0 0",
                               strobe_cnt - s0, playing, saw_rd);
        end
        sb_q.delete();
        stop_play();
    endtask

    task automatic test_tempo_zero();
        bit ok;
        int s0;
        tempo = 9'd0;
        chain_last = 4'd0;
        loop_enable = 1'b1;
        push_run(1, 4'd0, 1'b1);
        play_enable = 1'b1;
        wait_strobes(1, 20, ok);
        s0 = strobe_cnt;
        repeat (100) step();
        checks++;
        if (!ok || strobe_cnt !== s0 || playing !== 1'b1 || line_count !== 4'd0) begin
            errors++; $display("FAIL tempo_zero_hold: got ok=%b extra=%0d playing=%b line=%0d, required 1 0 1 0",
                               ok, strobe_cnt - s0, playing, line_count);
        end
        sb_q.delete();
        stop_play();
    endtask

    task automatic test_pause();
        bit          ok;
        int          e;
        logic [63:0] got;
        tempo = 9'd120;
        chain_last = 4'd1;
        loop_enable = 1'b1;
        push_run(8, 4'd1, 1'b1);
        push_line(4'd0, 4'd0);
        play_enable = 1'b1;
        wait_strobes(8, 100, ok);
        play_enable = 1'b0;
        step();
        got = {current_entry[0], current_entry[1], current_entry[2], current_entry[3]};
        checks++;
        if (!ok || got !== {4{16'hFF00}} || playing !== 1'b0 || line_count !== 4'd0 ||
            chain_step !== 4'd0 || mem_rd_en !== 1'b0) begin
            errors++; $display("FAIL pause_silence: got ok=%b entries=%h playing=%b line=%0d step=%0d rd=%b, required 1 %h 0 0 0 0",
                               ok, got, playing, line_count, chain_step, mem_rd_en, {4{16'hFF00}});
        end
        repeat (3) step();
        e = cyc;
        play_enable = 1'b1;
        wait_strobes(1, 20, ok);
        checks++;
        if (!ok || last_strobe_cyc - e !== 8) begin
            errors++; $display("FAIL resume_latency: got ok=%b %0d edges, required 1 8", ok, last_strobe_cyc - e);
        end
        play_enable = 1'b0;
        stop_play();
    endtask

    initial begin
        rst_active_low = 1'b0;
        play_enable    = 1'b0;
        loop_enable    = 1'b0;
        tempo          = 9'd0;
        chain_last     = 4'd0;
        for (int i = 0; i < 4096; i++) ram[i] = 16'((i * 40503) ^ 16'h3C5A);
        ram[12'h0C0] = 16'h1234;
        ram[12'h0C1] = 16'h5678;
        ram[12'h0C2] = 16'h9ABC;
        ram[12'h0C3] = 16'hDEF0;
        for (int i = 0; i < 16; i++) chain_tab[i] = 6'(i + 7);
        chain_tab[0] = 6'd3;
        chain_tab[1] = 6'd5;

        test_reset();
        test_start();
        test_tempo_period();
        test_line_advance();
        test_chain_loop();
        test_end_of_song();
        test_tempo_zero();
        test_pause();

        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
